// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FP datapath blocks.
// Holds the float field widths, the converter FSM states and the packed word layout.
package fp_pkg;

   localparam int FP_BIAS  = 127;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] man;
   } fp_t;

   // Returns 32 for an all-zero word.
   function automatic logic [5:0] lzc32(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) n = 6'(31 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Rounds a normalized 32-bit magnitude to nearest-even and packs it.
// mag_i[31] is the hidden bit whenever zero_i is low.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic        sign_i,
   input  logic [7:0]  exp_i,
   input  logic [31:0] mag_i,
   input  logic        zero_i,
   output logic [31:0] word_o
);

   logic [22:0] man;
   logic        g;
   logic        st;
   logic        up;
   logic [23:0] inc;
   fp_t         res;

   always_comb begin
      man = mag_i[30:8];
      g   = mag_i[7];
      st  = |mag_i[6:0];
      up  = g & (st | man[0]);
      inc = {1'b0, man} + {23'd0, up};
      res = '0;
      if (!zero_i) begin
         res.sign = sign_i;
         res.exp  = inc[23] ? exp_i + 8'd1 : exp_i;
         res.man  = inc[23] ? 23'd0 : inc[22:0];
      end
   end

   assign word_o = res;

endmodule

// File: rtl/fp_from_int.sv
// Iterative 32-bit integer to single-precision converter.
// Normalizes with bounded left shifts, then rounds and packs in one cycle.
module fp_from_int
   import fp_pkg::*;
#(
   parameter int SHIFT_STEP = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic        zero_q, zero_d;
   logic [31:0] out_q, out_d;
   logic [31:0] rnd_word;
   logic [5:0]  lz;
   logic [5:0]  step;
   logic        neg;

   // Clamp the shift so the leading one lands exactly on bit 31.
   always_comb begin
      lz   = lzc32(mag_q);
      step = (lz > 6'(SHIFT_STEP)) ? 6'(SHIFT_STEP) : lz;
   end

   fp_round_pack u_round (
      .sign_i (sign_q),
      .exp_i  (exp_q),
      .mag_i  (mag_q),
      .zero_i (zero_q),
      .word_o (rnd_word)
   );

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      out_d   = out_q;
      neg     = in_signed & in_data[31];
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = neg;
               mag_d   = neg ? (~in_data + 32'd1) : in_data;
               exp_d   = 8'(FP_BIAS + 31);
               zero_d  = 1'b0;
               state_d = NORM;
            end
         end
         NORM: begin
            if (mag_q == 32'd0) begin
               zero_d  = 1'b1;
               state_d = ROUND;
            end else if (mag_q[31]) begin
               state_d = ROUND;
            end else begin
               mag_d = mag_q << step;
               exp_d = exp_q - {2'b00, step};
            end
         end
         ROUND: begin
            out_d   = rnd_word;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mag_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         out_q   <= out_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_q;

endmodule

// File: tb/tb_fp_from_int.sv
// Bench for fp_from_int: four instances (SHIFT_STEP 1,2,4,8) share stimulus
// and are checked against an arithmetic rounding model.
module tb_fp_from_int;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_signed;
   logic        out_ready;
   logic        ir [4];
   logic        ov [4];
   logic [31:0] od [4];
   logic        bz [4];

   int n_chk;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      fp_from_int #(.SHIFT_STEP(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (ir[g]),
         .in_data   (in_data),
         .in_signed (in_signed),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .out_data  (od[g]),
         .busy      (bz[g])
      );
   end

   function automatic logic [31:0] ref_fp(input logic [31:0] d,
                                          input logic sg);
      logic        neg;
      logic [63:0] m, q, rem, half;
      logic [8:0]  e;
      int          p, r;
      neg = sg & d[31];
      m = neg ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
      if (m == 64'd0) return 32'd0;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      e = 9'(127 + p);
      if (p <= 23) begin
         q = m << (23 - p);
      end else begin
         r = p - 23;
         q = m >> r;
         rem = m - (q << r);
         half = 64'd1 << (r - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 9'd1;
         end
      end
      return {neg, e[7:0], q[22:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] d, input logic sg,
                                  input int s);
      logic [63:0] m;
      int p;
      m = (sg & d[31]) ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
      if (m == 64'd0) return 3;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      return 3 + (31 - p + s - 1) / s;
   endfunction

   // Drives one operand into all instances, waits for every result while
   // holding out_ready low, then releases them together.
   task automatic do_conv(input logic [31:0] d, input logic sg,
                          output logic [31:0] res [4], output int lat [4],
                          output int unstable, output logic tmo);
      logic got [4];
      int   cnt;
      logic all;
      unstable = 0;
      tmo = 1'b0;
      for (int i = 0; i < 4; i++) begin
         got[i] = 1'b0;
         res[i] = 32'd0;
         lat[i] = 0;
      end
      in_data   = d;
      in_signed = sg;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      cnt = 1;
      forever begin
         all = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (ov[i] && !got[i]) begin
               got[i] = 1'b1;
               res[i] = od[i];
               lat[i] = cnt;
            end else if (got[i] && (!ov[i] || od[i] !== res[i])) begin
               unstable++;
            end
            if (!got[i]) all = 1'b0;
         end
         if (all) break;
         if (cnt > 100) begin
            tmo = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cnt++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic check_conv(input string nm, input logic [31:0] d,
                             input logic sg, input logic [31:0] exp_w);
      logic [31:0] res [4];
      int lat [4];
      int uns;
      logic tmo;
      int el;
      do_conv(d, sg, res, lat, uns, tmo);
      n_chk++;
      if (tmo !== 1'b0 || uns != 0) begin
         n_fail++;
         $display("FAIL %s handshake: timeout=%0b unstable=%0d required 0/0",
                  nm, tmo, uns);
      end
      for (int i = 0; i < 4; i++) begin
         el = ref_lat(d, sg, 1 << i);
         n_chk++;
         if (res[i] !== exp_w) begin
            n_fail++;
            $display("FAIL %s data step=%0d: got %08h required %08h",
                     nm, 1 << i, res[i], exp_w);
         end
         n_chk++;
         if (lat[i] != el) begin
            n_fail++;
            $display("FAIL %s latency step=%0d: got %0d required %0d",
                     nm, 1 << i, lat[i], el);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 32'd0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if ({ir[i], ov[i], bz[i], od[i]} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset inst%0d: rdy/vld/busy/data %b%b%b %08h required 100 00000000",
                     i, ir[i], ov[i], bz[i], od[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      check_conv("s_one",   32'h00000001, 1'b1, 32'h3F800000);
      check_conv("s_m1",    32'hFFFFFFFF, 1'b1, 32'hBF800000);
      check_conv("s_zero",  32'h00000000, 1'b1, 32'h00000000);
      check_conv("u_zero",  32'h00000000, 1'b0, 32'h00000000);
      check_conv("s_min",   32'h80000000, 1'b1, 32'hCF000000);
      check_conv("u_2p31",  32'h80000000, 1'b0, 32'h4F000000);
      check_conv("tie_even",32'h01000001, 1'b0, 32'h4B800000);
      check_conv("tie_up",  32'h01000003, 1'b0, 32'h4B800002);
      check_conv("u_max",   32'hFFFFFFFF, 1'b0, 32'h4F800000);
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      int w;
      in_data = 32'd7;
      in_signed = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w = 0;
      while (!(ov[0] && ov[1] && ov[2] && ov[3]) && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      n_chk++;
      if (w >= 100) begin
         n_fail++;
         $display("FAIL bp_wait: out_valid never rose, got 0 required 1");
      end
      held = od[0];
      n_chk++;
      if (held !== 32'h40E00000) begin
         n_fail++;
         $display("FAIL bp_data: got %08h required 40e00000", held);
      end
      for (int c = 0; c < 10; c++) begin
         in_valid = (c == 4);
         in_data = 32'h12345678;
         @(posedge clk);
         #1;
         n_chk++;
         if (od[0] !== held || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall c=%0d: data %08h vld %b rdy %b required %08h 1 0",
                     c, od[0], ov[0], ir[0], held);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_chk++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: rdy %b vld %b required 1 0", ir[0], ov[0]);
      end
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (bz[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_ignored: busy %b required 0", bz[0]);
      end
   endtask

   task automatic test_reset_mid();
      in_data = 32'd1;
      in_signed = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: vld %b rdy %b busy %b required 0 1 0",
                  ov[0], ir[0], bz[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_conv("after_rst", 32'd5, 1'b0, 32'h40A00000);
   endtask

   task automatic test_sweep();
      logic [31:0] d;
      logic sg;
      for (int k = 0; k < 40; k++) begin
         d = $urandom >> $urandom_range(0, 31);
         sg = 1'($urandom_range(0, 1));
         if (sg && $urandom_range(0, 1) == 1) d = -d;
         check_conv("sweep", d, sg, ref_fp(d, sg));
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_from_int.md
Name: fp_from_int

Overview:
- Iterative converter from a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision word.
- Produces the float operands consumed by the floating-point adder path, acting as the producing end of the FP-word interface.
- Normalizes by bounded left shifts, one step per cycle, then rounds to nearest-even and packs.
- Uses valid/ready handshakes on both sides.

Parameters:
- SHIFT_STEP, 1, maximum left-shift bits per NORM cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_signed are valid.
- in_ready  output  1  converter can accept an operand.
- in_data  input  32  integer operand.
- in_signed  input  1  1 = two's complement, 0 = unsigned.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  packed float {sign, exp[7:0], man[22:0]}.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, internal mag/exp/sign cleared. Reset mid-conversion discards the operand; no partial result is ever output.
- States: IDLE, NORM, ROUND, DONE. in_ready=(state==IDLE); out_valid=(state==DONE).
- IDLE: on in_valid&in_ready, latch the operand and go to NORM.
  - sign = in_signed & in_data[31].
  - mag = sign ? -in_data : in_data, as a 32-bit unsigned value; 0x80000000 signed gives mag 0x80000000.
  - exp = 158, i.e. 127+31.
- NORM: each cycle one of three actions.
  - mag==0: go to ROUND with zero flag set.
  - mag[31]==1: go to ROUND.
  - Otherwise: shift mag left by s = min(SHIFT_STEP, leading zeros of mag) and set exp -= s; stay in NORM.
  - Shift count never overshoots mag[31].
- ROUND, one cycle, result registered into out_data:
  - man = mag[30:8], g = mag[7], st = |mag[6:0].
  - Round up when g & (st | man[0]). Use a 24-bit increment; on carry-out, man=0 and exp+1.
  - Zero flag forces out_data = 0x00000000, with positive sign even for zero input.
  - Exponent never overflows (max 159); no denormals arise.
  - Go to DONE.
- DONE: out_data stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE; in_ready rises the following cycle. There is no accept in the same cycle as delivery.
- Latency: accept edge to out_valid = 3 + ceil(L/SHIFT_STEP) cycles, where L = leading zeros of mag. Zero input takes 3 cycles.
- in_data changes while not in IDLE are ignored.
- No exceptions or flags are produced; all integer inputs are exactly representable or rounded.

Decomposition:
- Shared package fp_pkg holds:
  - FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23.
  - A state enum {IDLE, NORM, ROUND, DONE}.
  - A packed float struct {sign, exp, man}.
  - These are reused by the adder-side blocks.
- One sub-module, fp_round_pack: combinational {sign, exp, mag[31:0], zero} -> packed 32-bit word with round-to-nearest-even, used in the ROUND state. The FSM and shifter stay in fp_from_int.

Test Plan:
- Signed 1, SHIFT_STEP=1 -> out_data 0x3F800000; out_valid exactly 34 cycles after accept. Signed -1 -> 0xBF800000.
- Zero (signed and unsigned) -> 0x00000000 after 3 cycles. Signed 0x80000000 -> 0xCF000000 in 3 cycles. Unsigned 0x80000000 -> 0x4F000000.
- Rounding:
  - 0x01000001 -> 0x4B800000 (tie, even, no increment).
  - 0x01000003 -> 0x4B800002 (tie, round up).
  - Unsigned 0xFFFFFFFF -> 0x4F800000 (mantissa carry into exponent).
- Backpressure: out_ready held 0 for 10 cycles -> out_data/out_valid stable, in_ready=0, a second in_valid pulse is ignored. Releasing out_ready -> in_ready=1 next cycle.
- Reset mid-NORM with input 1: assert rst_n=0 -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, convert 5 -> 0x40A00000 with no trace of the aborted operand.
- Sweep SHIFT_STEP in {1, 2, 4, 8} with random signed/unsigned inputs against a reference model.
  - Checks: bit-exact results, latency formula, handshake invariants (out_data stable under stall).
